// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: per-instruction state sequence over a shared
// datapath, memory-ready stalls and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q;
  state_t state_d;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  assign state = state_q;

  // Everything is gated by rst_n so no enable can leak out during reset.
  always_comb begin
    state_d       = FETCH;
    retire        = 1'b0;
    illegal_op    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          state_d   = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (op)
            OP_LW, OP_SW: state_d = MEM_ADDR;
            OP_R:         state_d = R_EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = ADDI_EXEC;
            default: begin
              state_d    = FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (op == OP_LW) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          state_d  = mem_ready ? MEM_WB : MEM_RD;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          state_d   = mem_ready ? FETCH : MEM_WR;
          retire    = mem_ready;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = R_WB;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          retire        = 1'b1;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          retire    = 1'b1;
        end
        ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = ADDI_WB;
        end
        ADDI_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction expected state
// sequences are queued and checked each cycle against a control table.
module tb_multicycle_control;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       op;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic             mr;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             expq[$];
  logic [CNT_W-1:0] model_cnt;
  int               n_tests = 0;
  int               n_fail  = 0;

  logic [15:0] dut_ctrl;
  assign dut_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source};

  // Control word per state from the specification's action table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; iod = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rdst = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      4'd9:  begin pw = 1'b1; psrc = 2'b10; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: rw = 1'b1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rmr();
    return 1'($urandom);
  endfunction

  // One cycle: drive inputs, queue what this cycle must look like.
  task automatic step(input logic [5:0] o, input logic mr, input logic [3:0] st,
                      input logic ill, input logic ret);
    exp_t e;
    op = o;
    mem_ready = mr;
    e.st = st; e.mr = mr; e.ill = ill; e.cnt = model_cnt;
    expq.push_back(e);
    if (ret) model_cnt = model_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, output int cyc);
    logic ill;
    ill = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
    cyc = 0;
    for (int i = 0; i < fw; i++) begin step(rop(), 1'b0, 4'd0, 1'b0, 1'b0); cyc++; end
    step(rop(), 1'b1, 4'd0, 1'b0, 1'b0); cyc++;
    step(o, rmr(), 4'd1, ill, 1'b0); cyc++;
    case (o)
      6'b000000: begin
        step(rop(), rmr(), 4'd6, 1'b0, 1'b0);
        step(rop(), rmr(), 4'd7, 1'b0, 1'b1); cyc += 2;
      end
      6'b001000: begin
        step(rop(), rmr(), 4'd10, 1'b0, 1'b0);
        step(rop(), rmr(), 4'd11, 1'b0, 1'b1); cyc += 2;
      end
      6'b000100: begin step(rop(), rmr(), 4'd8, 1'b0, 1'b1); cyc++; end
      6'b000010: begin step(rop(), rmr(), 4'd9, 1'b0, 1'b1); cyc++; end
      6'b100011: begin
        step(o, rmr(), 4'd2, 1'b0, 1'b0); cyc++;
        for (int i = 0; i < mw; i++) begin step(rop(), 1'b0, 4'd3, 1'b0, 1'b0); cyc++; end
        step(rop(), 1'b1, 4'd3, 1'b0, 1'b0);
        step(rop(), rmr(), 4'd4, 1'b0, 1'b1); cyc += 2;
      end
      6'b101011: begin
        step(o, rmr(), 4'd2, 1'b0, 1'b0); cyc++;
        for (int i = 0; i < mw; i++) begin step(rop(), 1'b0, 4'd5, 1'b0, 1'b0); cyc++; end
        step(rop(), 1'b1, 4'd5, 1'b0, 1'b1); cyc++;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && expq.size() > 0) begin
      e = expq.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'(dut_ctrl), 32'(exp_ctrl(e.st, e.mr)));
      chk("illegal_op", 32'(illegal_op), 32'(e.ill));
      chk("instr_count", 32'(instr_count), 32'(e.cnt));
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      chk("rw_mw_excl", 32'(reg_write & mem_write), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    model_cnt = '0;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    op = 6'b000000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'(dut_ctrl), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    rst_n = 1'b1;

    run_instr(6'b000000, 0, 0, cyc); chk("lat_r", cyc, 4);
    chk("cnt_after_r", 32'(instr_count), 32'd1);
    run_instr(6'b100011, 0, 3, cyc); chk("lat_lw_wait3", cyc, 8);
    run_instr(6'b100011, 0, 0, cyc); chk("lat_lw", cyc, 5);
    run_instr(6'b101011, 0, 0, cyc); chk("lat_sw", cyc, 4);
    chk("cnt_after_sw", 32'(instr_count), 32'd4);
    run_instr(6'b000100, 0, 0, cyc); chk("lat_beq", cyc, 3);
    run_instr(6'b000010, 0, 0, cyc); chk("lat_j", cyc, 3);
    run_instr(6'b111111, 0, 0, cyc); chk("lat_illegal", cyc, 2);
    chk("cnt_after_illegal", 32'(instr_count), 32'd6);
    run_instr(6'b001000, 0, 0, cyc); chk("lat_addi", cyc, 4);
    run_instr(6'b000000, 2, 0, cyc); chk("lat_r_fetch_wait2", cyc, 6);
    run_instr(6'b101011, 0, 2, cyc); chk("lat_sw_wait2", cyc, 6);
    for (int i = 0; i < 6; i++) run_instr(6'b000010, 0, 0, cyc);
    chk("cnt_15", 32'(instr_count), 32'd15);
    run_instr(6'b000100, 0, 0, cyc);
    chk("cnt_wrap", 32'(instr_count), 32'd0);
    run_instr(6'b000000, 0, 0, cyc);
    chk("cnt_after_wrap", 32'(instr_count), 32'd1);

    // Abandon a stalled lw in MEM_RD with an asynchronous reset.
    step(rop(), 1'b1, 4'd0, 1'b0, 1'b0);
    step(6'b100011, 1'b1, 4'd1, 1'b0, 1'b0);
    step(6'b100011, 1'b1, 4'd2, 1'b0, 1'b0);
    step(rop(), 1'b0, 4'd3, 1'b0, 1'b0);
    chk("pre_rst_state", 32'(state), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_ctrl", 32'(dut_ctrl), 32'd0);
    chk("mid_rst_count", 32'(instr_count), 32'd0);
    chk("mid_rst_illegal", 32'(illegal_op), 32'd0);
    expq.delete();
    model_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(6'b000000, 0, 0, cyc);
    chk("cnt_after_mid_rst", 32'(instr_count), 32'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
